qa_wrapper_mc: RTL and testbench

Multi-channel successor to the single-stream QA wrapper. Accepts tagged input words for N_CHAN independent channels and buffers each channel in its own circular FIFO. A round-robin arbiter drains all channels onto one tagged output stream with valid/ready backpressure. Channel overflows are reported in-band as error-code words tagged with the offending channel. Sits between the QA stimulus source and the QA result collector.

---
 rtl/qa_wrapper_mc.sv | 145 ++++++++++++++
 tb/tb_qa_wrapper_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qa_wrapper_mc.sv
// Multi-channel QA wrapper: per-channel circular FIFOs drained round-robin onto one tagged
// valid/ready stream, with in-band overflow error words. Define QA_OVF_COUNT_EN for per-channel drop counters.
module qa_wrapper_mc #(
  parameter int unsigned     WDTH             = 32,
  parameter int unsigned     LOG_N_CHAN       = 2,
  parameter int unsigned     LOG_DEPTH        = 4,
  parameter logic [WDTH-1:0] WRITE_ERROR_CODE = 32'hFFFF_FFF1,
  parameter int unsigned     OVF_CNT_W        = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [WDTH-1:0]                       in_data,
  input  logic [LOG_N_CHAN-1:0]                 in_chan,
  input  logic                                  in_nd,
  output logic [WDTH-1:0]                       out_data,
  output logic [LOG_N_CHAN-1:0]                 out_chan,
  output logic                                  out_nd,
  input  logic                                  out_ready,
  output logic [(2**LOG_N_CHAN)*OVF_CNT_W-1:0]  ovf_count
);

  localparam int unsigned        N_CHAN = 2**LOG_N_CHAN;
  localparam int unsigned        DEPTH  = 2**LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL   = {1'b1, {LOG_DEPTH{1'b0}}};

  logic [WDTH-1:0]       r_mem    [N_CHAN][DEPTH];
  logic [LOG_DEPTH-1:0]  r_wr_ptr [N_CHAN];
  logic [LOG_DEPTH-1:0]  r_rd_ptr [N_CHAN];
  logic [LOG_DEPTH:0]    r_count  [N_CHAN];
  logic [N_CHAN-1:0]     r_err_pend;
  logic [LOG_N_CHAN-1:0] r_rr_ptr;
  logic [WDTH-1:0]       r_out_data;
  logic [LOG_N_CHAN-1:0] r_out_chan;
  logic                  r_out_nd;

  logic                  w_slot_free;
  logic                  w_wr_full;
  logic                  w_win_found;
  logic                  w_win_err;
  logic                  w_grant;
  logic [LOG_N_CHAN-1:0] w_win_chan;
  logic [WDTH-1:0]       w_head;
  logic [N_CHAN-1:0]     w_push;
  logic [N_CHAN-1:0]     w_pop;
  logic [N_CHAN-1:0]     w_ovf;

  assign w_slot_free = ~r_out_nd | out_ready;
  assign w_wr_full   = (r_count[in_chan] == FULL);

  always_comb begin : arb
    logic [LOG_N_CHAN-1:0] v_idx;
    w_win_found = 1'b0;
    w_win_chan  = '0;
    v_idx       = '0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      v_idx = r_rr_ptr + LOG_N_CHAN'(i);
      if (!w_win_found && (r_err_pend[v_idx] || (r_count[v_idx] != '0))) begin
        w_win_found = 1'b1;
        w_win_chan  = v_idx;
      end
    end
  end

  assign w_win_err = r_err_pend[w_win_chan];
  assign w_grant   = w_slot_free & w_win_found;
  assign w_head    = r_mem[w_win_chan][r_rd_ptr[w_win_chan]];

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    w_ovf  = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      w_push[c] = in_nd & ~w_wr_full & (in_chan == LOG_N_CHAN'(c));
      w_ovf[c]  = in_nd &  w_wr_full & (in_chan == LOG_N_CHAN'(c));
      w_pop[c]  = w_grant & ~w_win_err & (w_win_chan == LOG_N_CHAN'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (in_nd && !w_wr_full) r_mem[in_chan][r_wr_ptr[in_chan]] <= in_data;
  end

  // A new overflow wins over clearing on error-word emission, so a second error word follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CHAN; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
      r_err_pend <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CHAN; c++) begin
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + LOG_DEPTH'(1);
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + LOG_DEPTH'(1);
        r_count[c] <= r_count[c] + (LOG_DEPTH+1)'(w_push[c]) - (LOG_DEPTH+1)'(w_pop[c]);
        if (w_ovf[c])
          r_err_pend[c] <= 1'b1;
        else if (w_grant && w_win_err && (w_win_chan == LOG_N_CHAN'(c)))
          r_err_pend[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_chan <= '0;
      r_out_nd   <= 1'b0;
      r_rr_ptr   <= '0;
    end else if (w_grant) begin
      r_out_data <= w_win_err ? WRITE_ERROR_CODE : w_head;
      r_out_chan <= w_win_chan;
      r_out_nd   <= 1'b1;
      r_rr_ptr   <= w_win_chan + LOG_N_CHAN'(1);
    end else if (w_slot_free) begin
      r_out_nd <= 1'b0;
    end
  end

  assign out_data = r_out_data;
  assign out_chan = r_out_chan;
  assign out_nd   = r_out_nd;

`ifdef QA_OVF_COUNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_cnt [N_CHAN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CHAN; c++) r_ovf_cnt[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CHAN; c++)
        if (w_ovf[c] && (r_ovf_cnt[c] != '1)) r_ovf_cnt[c] <= r_ovf_cnt[c] + OVF_CNT_W'(1);
    end
  end

  always_comb begin
    ovf_count = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) ovf_count[c*OVF_CNT_W +: OVF_CNT_W] = r_ovf_cnt[c];
  end
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_qa_wrapper_mc.sv
// Randomized bench for qa_wrapper_mc against a queue-based channel/arbiter model.
module tb_qa_wrapper_mc;
  localparam int WDTH = 32, LNC = 2, LD = 2, OVW = 4, NCH = 4, DEPTH = 4;
  localparam logic [31:0] ERR = 32'hFFFF_FFF1;
`ifdef QA_OVF_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_chan = '0;
  logic        in_nd = 1'b0, out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_chan;
  logic        out_nd;
  logic [NCH*OVW-1:0] ovf_count;

  int checks = 0, errors = 0;

  // Reference model: one queue per channel, pending-error flags, round-robin pointer, output slot.
  logic [31:0] q[NCH][$];
  bit          m_pend[NCH];
  int          m_ovf[NCH];
  int          m_rr;
  bit          m_nd;
  int          m_chan;
  logic [31:0] m_data;

  qa_wrapper_mc #(
    .WDTH(WDTH), .LOG_N_CHAN(LNC), .LOG_DEPTH(LD),
    .WRITE_ERROR_CODE(ERR), .OVF_CNT_W(OVW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_chan(in_chan), .in_nd(in_nd),
    .out_data(out_data), .out_chan(out_chan), .out_nd(out_nd), .out_ready(out_ready),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      m_pend[c] = 1'b0;
      m_ovf[c]  = 0;
    end
    m_rr = 0; m_nd = 1'b0; m_chan = 0; m_data = '0;
  endtask

  function automatic logic [NCH*OVW-1:0] exp_ovf();
    logic [NCH*OVW-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*OVW +: OVW] = CNT_EN ? OVW'(m_ovf[c]) : '0;
    return v;
  endfunction

  // Drive one cycle's inputs, advance the model by one clock, then wait past the edge.
  task automatic cycle(input bit nd, input int ch, input logic [31:0] d, input bit rdy);
    bit ovf;
    int win;
    in_nd = nd; in_chan = 2'(ch); in_data = d; out_ready = rdy;
    ovf = nd && (q[ch].size() == DEPTH);
    if (!m_nd || rdy) begin
      win = -1;
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (m_rr + i) % NCH;
        if (win < 0 && (m_pend[c] || q[c].size() > 0)) win = c;
      end
      if (win < 0) m_nd = 1'b0;
      else begin
        m_nd = 1'b1;
        m_chan = win;
        if (m_pend[win]) begin
          m_data = ERR;
          m_pend[win] = 1'b0;
        end else m_data = q[win].pop_front();
        m_rr = (win + 1) % NCH;
      end
    end
    if (nd) begin
      if (ovf) begin
        m_pend[ch] = 1'b1;
        if (m_ovf[ch] < (2**OVW - 1)) m_ovf[ch]++;
      end else q[ch].push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_nd = 1'b0;
    model_clear();
    #20;
    rst_n = 1'b1;
    cycle(0, 0, '0, out_ready);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_nd, out_chan, out_data, ovf_count} !== '0) begin
      errors++;
      $display("FAIL reset_during: got nd=%0b ch=%0d data=%h ovf=%h want all zero", out_nd, out_chan, out_data, ovf_count);
    end
    do_reset();
    checks++;
    if ({out_nd, out_chan, out_data, ovf_count} !== '0) begin
      errors++;
      $display("FAIL reset_after: got nd=%0b ch=%0d data=%h ovf=%h want all zero", out_nd, out_chan, out_data, ovf_count);
    end
  endtask

  task automatic test_single_word();
    cycle(1, 2, 32'h0000_00A5, 1);
    checks++;
    if (out_nd !== 1'b0) begin
      errors++; $display("FAIL single_lat0: got nd=%0b want 0", out_nd);
    end
    cycle(0, 0, '0, 1);
    checks++;
    if ({out_nd, out_chan, out_data} !== {1'b1, 2'd2, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL single_out: got nd=%0b ch=%0d data=%h want nd=1 ch=2 data=000000a5", out_nd, out_chan, out_data);
    end
    cycle(0, 0, '0, 1);
    checks++;
    if (out_nd !== 1'b0) begin
      errors++; $display("FAIL single_after: got nd=%0b want 0", out_nd);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d[8];
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 2; k++) cycle(1, c, 32'hC0 + 32'h10 * c + k, 0);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) exp_d[k*NCH + c] = 32'hC0 + 32'h10 * c + k;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) cycle(0, 0, '0, 1);
      checks++;
      if ({out_nd, out_chan, out_data} !== {1'b1, 2'(j % NCH), exp_d[j]}) begin
        errors++;
        $display("FAIL rr_order[%0d]: got nd=%0b ch=%0d data=%h want nd=1 ch=%0d data=%h",
                 j, out_nd, out_chan, out_data, j % NCH, exp_d[j]);
      end
    end
    cycle(0, 0, '0, 1);
    checks++;
    if (out_nd !== 1'b0) begin
      errors++; $display("FAIL rr_drained: got nd=%0b want 0", out_nd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int c;
    d = $urandom;
    c = $urandom_range(0, NCH - 1);
    cycle(1, c, d, 0);
    cycle(0, 0, '0, 0);
    for (int j = 0; j < 5; j++) begin
      cycle(0, 0, '0, 0);
      checks++;
      if ({out_nd, out_chan, out_data} !== {1'b1, 2'(c), d}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got nd=%0b ch=%0d data=%h want nd=1 ch=%0d data=%h", j, out_nd, out_chan, out_data, c, d);
      end
    end
    cycle(0, 0, '0, 1);
    checks++;
    if (out_nd !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup: got nd=%0b data=%h want nd=0", out_nd, out_data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w[6];
    logic [31:0] blk;
    do_reset();
    blk = $urandom;
    cycle(1, 0, blk, 0);
    for (int k = 0; k < 6; k++) begin
      w[k] = $urandom;
      cycle(1, 1, w[k], 0);
    end
    checks++;
    if (ovf_count[OVW +: OVW] !== (CNT_EN ? 4'd2 : 4'd0)) begin
      errors++; $display("FAIL ovf_count_ch1: got %0d want %0d", ovf_count[OVW +: OVW], CNT_EN ? 2 : 0);
    end
    checks++;
    if ({out_nd, out_chan, out_data} !== {1'b1, 2'd0, blk}) begin
      errors++; $display("FAIL ovf_blocker: got nd=%0b ch=%0d data=%h want nd=1 ch=0 data=%h", out_nd, out_chan, out_data, blk);
    end
    cycle(0, 0, '0, 1);
    checks++;
    if ({out_nd, out_chan, out_data} !== {1'b1, 2'd1, ERR}) begin
      errors++; $display("FAIL ovf_errword: got nd=%0b ch=%0d data=%h want nd=1 ch=1 data=%h", out_nd, out_chan, out_data, ERR);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, '0, 1);
      checks++;
      if ({out_nd, out_chan, out_data} !== {1'b1, 2'd1, w[k]}) begin
        errors++;
        $display("FAIL ovf_data[%0d]: got nd=%0b ch=%0d data=%h want nd=1 ch=1 data=%h", k, out_nd, out_chan, out_data, w[k]);
      end
    end
    cycle(0, 0, '0, 1);
    checks++;
    if (out_nd !== 1'b0) begin
      errors++; $display("FAIL ovf_drained: got nd=%0b want 0", out_nd);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      bit nd, rdy;
      int ch;
      nd  = ($urandom_range(0, 99) < 65);
      rdy = ($urandom_range(0, 99) < ((n < 400) ? 75 : 30));
      ch  = ($urandom_range(0, 3) == 0) ? 2 : $urandom_range(0, NCH - 1);
      cycle(nd, ch, $urandom, rdy);
      checks++;
      if ({out_nd, out_chan, out_data} !== {m_nd, 2'(m_chan), m_data}) begin
        errors++;
        $display("FAIL rand_out[%0d]: got nd=%0b ch=%0d data=%h want nd=%0b ch=%0d data=%h",
                 n, out_nd, out_chan, out_data, m_nd, m_chan, m_data);
      end
      checks++;
      if (ovf_count !== exp_ovf()) begin
        errors++; $display("FAIL rand_ovf[%0d]: got %h want %h", n, ovf_count, exp_ovf());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, 2, $urandom, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_nd, out_chan, out_data} !== '0) begin
      errors++; $display("FAIL arst_immediate: got nd=%0b ch=%0d data=%h want all zero", out_nd, out_chan, out_data);
    end
    model_clear();
    #10;
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle(0, 0, '0, 1);
      checks++;
      if (out_nd !== 1'b0 || out_nd !== m_nd) begin
        errors++; $display("FAIL arst_quiet[%0d]: got nd=%0b data=%h want nd=0", j, out_nd, out_data);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 25; k++) cycle(1, 3, $urandom, 0);
    checks++;
    if (ovf_count[3*OVW +: OVW] !== (CNT_EN ? 4'hF : 4'h0)) begin
      errors++; $display("FAIL sat_ch3: got %h want %h", ovf_count[3*OVW +: OVW], CNT_EN ? 4'hF : 4'h0);
    end
    checks++;
    if (ovf_count !== exp_ovf()) begin
      errors++; $display("FAIL sat_all: got %h want %h", ovf_count, exp_ovf());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_random();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
